// File: rtl/step_conditioner.sv
// Debounced step push-button and mode switch producing one-cycle world-advance strobes.
// Define STEP_AUTO_EN to add the periodic auto-step generator used while mode = 1.
module step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_PERIOD     = 25000000
) (
  input  logic       clock_50,
  input  logic       reset_key,
  input  logic       step_key_n,
  input  logic       mode_sw,
  output logic       step_pulse,
  output logic       mode,
  output logic [7:0] step_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } btn_state_e;

  // Synchronizers; reset to the released-key / manual-switch levels.
  logic r_key_meta, r_key_sync;
  logic r_sw_meta, r_sw_sync;

  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
      r_sw_meta  <= 1'b0;
      r_sw_sync  <= 1'b0;
    end else begin
      r_key_meta <= step_key_n;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= mode_sw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  // Button debounce FSM.
  btn_state_e      r_state, w_state_next;
  logic [CntW-1:0] r_btn_cnt, w_btn_cnt_next;
  logic            w_press_req;

  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      r_state   <= StIdle;
      r_btn_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_btn_cnt <= w_btn_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_btn_cnt_next = r_btn_cnt;
    w_press_req    = 1'b0;
    case (r_state)
      StIdle: begin
        if (!r_key_sync) w_state_next = StPressWait;
      end
      StPressWait: begin
        if (r_key_sync) begin
          w_state_next = StIdle;
        end else if (r_btn_cnt == DebLast) begin
          w_state_next = StHeld;
          w_press_req  = 1'b1;
        end else begin
          w_btn_cnt_next = r_btn_cnt + 1'b1;
        end
      end
      StHeld: begin
        if (r_key_sync) w_state_next = StReleaseWait;
      end
      StReleaseWait: begin
        if (!r_key_sync) begin
          w_state_next = StHeld;
        end else if (r_btn_cnt == DebLast) begin
          w_state_next = StIdle;
        end else begin
          w_btn_cnt_next = r_btn_cnt + 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (w_state_next != r_state) w_btn_cnt_next = '0;
  end

  // Mode debounce: any cycle of agreement restarts the count.
  logic            r_mode, w_mode_next;
  logic [CntW-1:0] r_mode_cnt, w_mode_cnt_next;

  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      r_mode     <= 1'b0;
      r_mode_cnt <= '0;
    end else begin
      r_mode     <= w_mode_next;
      r_mode_cnt <= w_mode_cnt_next;
    end
  end

  always_comb begin
    w_mode_next     = r_mode;
    w_mode_cnt_next = '0;
    if (r_sw_sync != r_mode) begin
      if (r_mode_cnt == DebLast) begin
        w_mode_next = r_sw_sync;
      end else begin
        w_mode_cnt_next = r_mode_cnt + 1'b1;
      end
    end
  end

  logic w_auto_req;

`ifdef STEP_AUTO_EN
  localparam int unsigned AutoW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_PERIOD - 1);

  logic [AutoW-1:0] r_auto_cnt, w_auto_cnt_next;

  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= w_auto_cnt_next;
    end
  end

  // Held at zero in manual mode so the first tick lands a full period after mode rises.
  always_comb begin
    w_auto_cnt_next = '0;
    w_auto_req      = 1'b0;
    if (r_mode) begin
      if (r_auto_cnt == AutoLast) begin
        w_auto_req = 1'b1;
      end else begin
        w_auto_cnt_next = r_auto_cnt + 1'b1;
      end
    end
  end
`else
  // No auto generator; AUTO_PERIOD stays referenced so both builds share one parameter list.
  assign w_auto_req = 1'b0 & (|AUTO_PERIOD);
`endif

  // Manual presses only count in manual mode; simultaneous requests merge into one strobe.
  logic       w_step_req;
  logic       r_step_pulse;
  logic [7:0] r_step_count;

  assign w_step_req = (w_press_req & ~r_mode) | w_auto_req;

  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      r_step_pulse <= 1'b0;
      r_step_count <= 8'd0;
    end else begin
      r_step_pulse <= w_step_req;
      if (w_step_req) r_step_count <= r_step_count + 8'd1;
    end
  end

  assign step_pulse = r_step_pulse;
  assign mode       = r_mode;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_step_conditioner.sv
// Directed bench for step_conditioner with DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 10.
// Auto-step checks follow STEP_AUTO_EN; without it mode = 1 must yield no steps.
module tb_step_conditioner;

  logic       clock_50;
  logic       reset_key;
  logic       step_key_n;
  logic       mode_sw;
  logic       step_pulse;
  logic       mode;
  logic [7:0] step_count;

  step_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (10)
  ) dut (
    .clock_50  (clock_50),
    .reset_key (reset_key),
    .step_key_n(step_key_n),
    .mode_sw   (mode_sw),
    .step_pulse(step_pulse),
    .mode      (mode),
    .step_count(step_count)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  typedef struct packed {
    logic       rst;
    logic       key_n;
    logic       sw;
    logic [7:0] n;
    logic       e_pulse;
    logic       e_mode;
    logic [7:0] e_count;
    logic [7:0] e_seen;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   seen     = 0;

  function automatic void add(logic rst, logic key_n, logic sw, int n, logic e_pulse,
                              logic e_mode, int e_count, int e_seen);
    vec_t v;
    v.rst     = rst;
    v.key_n   = key_n;
    v.sw      = sw;
    v.n       = 8'(n);
    v.e_pulse = e_pulse;
    v.e_mode  = e_mode;
    v.e_count = 8'(e_count);
    v.e_seen  = 8'(e_seen);
    vecs.push_back(v);
  endfunction

  // One clock, then sample away from the edge; seen counts strobes since the last reset.
  task automatic tick();
    @(posedge clock_50);
    #1;
    if (reset_key) seen = 0;
    else if (step_pulse === 1'b1) seen++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int bad;
    int exp_cnt;
    reset_key  = 1'b1;
    step_key_n = 1'b1;
    mode_sw    = 1'b0;

    // rst, key_n, sw, cycles, pulse, mode, count, seen
    add(1, 1, 0,  3, 0, 0, 0, 0);
    add(0, 1, 0, 50, 0, 0, 0, 0);
    // Clean press: strobe 7 cycles after the key falls, no repeat while held.
    add(0, 0, 0,  6, 0, 0, 0, 0);
    add(0, 0, 0,  1, 1, 0, 1, 1);
    add(0, 0, 0,  1, 0, 0, 1, 1);
    add(0, 0, 0, 12, 0, 0, 1, 1);
    add(0, 1, 0, 20, 0, 0, 1, 1);
    add(0, 0, 0,  7, 1, 0, 2, 2);
    add(0, 1, 0, 15, 0, 0, 2, 2);
    // Bouncy release after a press never re-arms.
    add(0, 0, 0,  7, 1, 0, 3, 3);
    add(0, 1, 0,  2, 0, 0, 3, 3);
    add(0, 0, 0,  2, 0, 0, 3, 3);
    add(0, 1, 0,  2, 0, 0, 3, 3);
    add(0, 0, 0,  2, 0, 0, 3, 3);
    add(0, 1, 0, 15, 0, 0, 3, 3);
    // Bouncy press toggling every 2 cycles.
    add(1, 1, 0,  2, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, (i % 2 == 1), 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 10, 0, 0, 0, 0);
    // Switch glitch of 3 cycles is one short of the debounce window.
    add(0, 1, 1,  3, 0, 0, 0, 0);
    add(0, 1, 0, 10, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset_key  = vecs[i].rst;
      step_key_n = vecs[i].key_n;
      mode_sw    = vecs[i].sw;
      repeat (int'(vecs[i].n)) tick();
      check($sformatf("vec%0d_pulse", i), 32'(step_pulse), 32'(vecs[i].e_pulse));
      check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].e_mode));
      check($sformatf("vec%0d_count", i), 32'(step_count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_seen", i), 32'(seen), 32'(vecs[i].e_seen));
    end

    // Mode rise: 2 sync cycles plus 4 debounce cycles.
    reset_key = 1'b1;
    tick();
    tick();
    reset_key = 1'b0;
    mode_sw   = 1'b1;
    repeat (5) tick();
    check("mode_before_6", 32'(mode), 32'd0);
    tick();
    check("mode_at_6", 32'(mode), 32'd1);

`ifdef STEP_AUTO_EN
    bad = 0;
    repeat (9) begin
      tick();
      if (step_pulse !== 1'b0) bad++;
    end
    check("auto_first_gap", 32'(bad), 32'd0);
    tick();
    check("auto_first_pulse", 32'(step_pulse), 32'd1);
    check("auto_first_count", 32'(step_count), 32'd1);
    bad = 0;
    for (int k = 2; k <= 256; k++) begin
      repeat (9) begin
        tick();
        if (step_pulse !== 1'b0) bad++;
      end
      tick();
      if (step_pulse !== 1'b1) bad++;
    end
    check("auto_spacing", 32'(bad), 32'd0);
    check("auto_wrap_count", 32'(step_count), 32'd0);
    check("auto_seen_256", 32'(seen), 32'd256);
    exp_cnt = 6;
`else
    exp_cnt = 0;
`endif

    // Clean press in auto mode: no extra strobe, auto cadence untouched.
    bad = 0;
    step_key_n = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 21) step_key_n = 1'b1;
      tick();
      if (step_pulse !== ((exp_cnt != 0) && (i % 10 == 0))) bad++;
    end
    check("auto_press_spacing", 32'(bad), 32'd0);
    check("auto_press_count", 32'(step_count), 32'(exp_cnt));

    mode_sw = 1'b0;
    repeat (5) tick();
    check("mode_fall_before_6", 32'(mode), 32'd1);
    tick();
    check("mode_fall_at_6", 32'(mode), 32'd0);
    check("mode_fall_count", 32'(step_count), 32'(exp_cnt));

    // Reset during PRESS_WAIT aborts the press; a still-low key restarts the full latency.
    reset_key = 1'b1;
    tick();
    tick();
    reset_key  = 1'b0;
    step_key_n = 1'b0;
    repeat (5) tick();
    check("abort_no_pulse_yet", 32'(seen), 32'd0);
    reset_key = 1'b1;
    tick();
    check("abort_reset_pulse", 32'(step_pulse), 32'd0);
    reset_key = 1'b0;
    tick();
    check("abort_after_reset_pulse", 32'(step_pulse), 32'd0);
    repeat (5) tick();
    check("abort_seen_before_7", 32'(seen), 32'd0);
    tick();
    check("abort_pulse_at_7", 32'(step_pulse), 32'd1);
    check("abort_count", 32'(step_count), 32'd1);
    step_key_n = 1'b1;
    repeat (10) tick();
    check("abort_seen_total", 32'(seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_conditioner.md
STEP_CONDITIONER -- requirements
Module: step_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a key/switch change (20 ms at 50 MHz).
REQ-002 SHALL have parameter AUTO_PERIOD, default 25000000, clock_50 cycles between automatic step pulses (0.5 s).
REQ-003 SHALL have port clock_50, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_key, input, 1, synchronous active-high reset.
REQ-005 SHALL have port step_key_n, input, 1, raw asynchronous step push-button, active-low (pressed = 0).
REQ-006 SHALL have port mode_sw, input, 1, raw asynchronous mode switch (1 = auto, 0 = manual).
REQ-007 SHALL have port step_pulse, output, 1, one-cycle world-advance strobe.
REQ-008 SHALL have port mode, output, 1, debounced mode level.
REQ-009 SHALL have port step_count, output, 8, count of step_pulse strobes issued, wraps 255 -> 0.

Function
REQ-010 SHALL pass step_key_n and mode_sw each through a two-flop synchronizer before any other use.
REQ-011 SHALL run a 4-state button FSM: IDLE (released), PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when synchronized key = 0; debounce counter cleared.
REQ-013 PRESS_WAIT: counter increments while key = 0; key = 1 before count reaches DEBOUNCE_CYCLES-1 -> IDLE, no pulse.
REQ-014 PRESS_WAIT -> HELD when counter reaches DEBOUNCE_CYCLES-1 with key still 0; manual step request raised for exactly that transition cycle.
REQ-015 HELD -> RELEASE_WAIT when key = 1; held key SHALL never generate further requests (no auto-repeat).
REQ-016 RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive key = 1 cycles; key = 0 earlier -> HELD.
REQ-017 mode SHALL change only after synchronized mode_sw differs from mode for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
REQ-018 Manual requests SHALL be honoured only while mode = 0; requests in auto mode SHALL be discarded (button FSM still runs).
REQ-019 step_pulse SHALL be registered: asserted the cycle after the request, high for exactly one cycle.
REQ-020 step_count SHALL increment in the same cycle step_pulse is high; 8-bit modulo arithmetic.
REQ-021 Auto and manual requests in the same cycle SHALL produce a single step_pulse (one count increment).
REQ-022 Debounce counters SHALL saturate-free: width ceil(log2(DEBOUNCE_CYCLES))+1, cleared on every state change.

Reset
REQ-023 While reset_key = 1 at a clock edge: FSM = IDLE, all counters = 0, step_pulse = 0, mode = 0, step_count = 0, synchronizer flops = idle levels (key 1, switch 0).
REQ-024 Reset mid-debounce or mid-pulse SHALL abort it; no pulse SHALL be emitted in the cycle after reset deasserts.
REQ-025 After deassertion, mode SHALL reflect a held mode_sw = 1 no sooner than 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-026 Macro STEP_AUTO_EN defined: auto tick counter counts 0..AUTO_PERIOD-1 while mode = 1, raising an auto request on wrap; counter cleared while mode = 0, so first auto pulse comes AUTO_PERIOD cycles after mode rises.
REQ-027 STEP_AUTO_EN undefined: no auto counter synthesized; mode = 1 produces no steps; mode output and debounce unchanged.

Verification (bench uses DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 10)
REQ-028 Reset 3 cycles, key held 1, switch 0 -> step_pulse 0, mode 0, step_count 0 throughout 50 cycles.
REQ-029 Manual mode, key low 20 cycles then high -> exactly one step_pulse, 2 + 4 + 1 cycles after key falls; step_count = 1.
REQ-030 Key bounce 0/1 toggling every 2 cycles for 20 cycles then high -> no step_pulse, step_count 0.
REQ-031 STEP_AUTO_EN defined, switch 1 held -> mode rises after 6 cycles; step_pulse every 10 cycles; 256 pulses -> step_count wraps to 0.
REQ-032 Auto mode, clean key press -> no extra pulse; pulse spacing stays 10.
REQ-033 Reset asserted during PRESS_WAIT (cycle 4 of press) -> no pulse; key still low after release of reset -> one pulse 7 cycles later.
